// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int CHAN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or after ptr, wrapping mod NREQ.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]   req,
  input  logic [CHAN_W-1:0] ptr,
  output logic [NREQ-1:0]   grant,
  output logic [CHAN_W-1:0] idx,
  output logic              any
);

  int pos;

  // Inner loop uses only constant bit indices so the search stays a plain priority mux.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a value held (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!any && (i == pos) && req[i]) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = CHAN_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte requesters.
// Optional watchdog on the WAIT state is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 2048
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  output logic [CHAN_W-1:0]      tx_chan,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   err_timeout
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("uart_tx_arbiter: illegal NREQ or TIMEOUT");
  end

  // Gap counter only ever holds GAP-1 down to 0.
  localparam int              GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  arb_state_e        state_q, state_d;
  logic [CHAN_W-1:0] ptr_q, ptr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              tx_start_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic [CHAN_W-1:0] tx_chan_d;

  logic [NREQ-1:0]   pick_grant;
  logic [CHAN_W-1:0] pick_idx;
  logic              pick_any;
  logic [BYTE_W-1:0] pick_byte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int               WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_d;
`endif

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // One-hot grant selects the winning byte.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) pick_byte = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign req_ready = (state_q == ST_IDLE) ? pick_grant : '0;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gap_d      = gap_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    tx_chan_d  = tx_chan;
`ifdef UART_ARB_TIMEOUT_EN
    wdog_d     = wdog_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          tx_start_d = 1'b1;
          tx_data_d  = pick_byte;
          tx_chan_d  = pick_idx;
          ptr_d      = (pick_idx == CHAN_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A tx_done coinciding with tx_start is deliberately ignored here.
        state_d = ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; all state here is flops, so every register is cleared explicitly.
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gap_q    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      tx_chan  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wdog_q      <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gap_q    <= gap_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
      tx_chan  <= tx_chan_d;
`ifdef UART_ARB_TIMEOUT_EN
      wdog_q      <= wdog_d;
      err_timeout <= err_d;
`endif
    end
  end

`ifndef UART_ARB_TIMEOUT_EN
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a cycle-timestamp reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [2:0]  tx_chan;
  logic        tx_done;
  logic        busy;
  logic        err_timeout;

  logic [3:0]  g0_valid;
  logic [31:0] g0_data;
  logic [3:0]  g0_ready;
  logic        g0_tx_start;
  logic [7:0]  g0_tx_data;
  logic [2:0]  g0_tx_chan;
  logic        g0_done;
  logic        g0_busy;
  logic        g0_err;

  uart_tx_arbiter #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_chan     (tx_chan),
    .tx_done     (tx_done),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  uart_tx_arbiter #(.NREQ(NREQ), .GAP(0), .TIMEOUT(TIMEOUT)) u_dut_g0 (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (g0_valid),
    .req_data    (g0_data),
    .req_ready   (g0_ready),
    .tx_start    (g0_tx_start),
    .tx_data     (g0_tx_data),
    .tx_chan     (g0_tx_chan),
    .tx_done     (g0_done),
    .busy        (g0_busy),
    .err_timeout (g0_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int cyc;

  // Reference model: absolute cycle numbers of the last grant, the transmitter's done pulse,
  // the last WAIT cycle, the first cycle the arbiter is free again and the watchdog pulse.
  int         m_ptr;
  int         free_at;
  int         last_grant;
  int         done_at;
  int         wait_end;
  int         err_at;
  logic [7:0] exp_data;
  logic [2:0] exp_chan;
  int         order[$];
  bit         to_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int rr_winner(input logic [3:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (((v >> ((p + k) % NREQ)) & 4'd1) != 4'd0) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic reset_model(input int c);
    m_ptr      = 0;
    free_at    = c;
    last_grant = -10;
    done_at    = -1;
    wait_end   = -1;
    err_at     = -1;
    exp_data   = 8'h00;
    exp_chan   = 3'd0;
  endtask

  // One clock cycle on the main DUT: drive, compare against the model, advance the model.
  task automatic main_cycle(input bit all_valid, input int fixed_d, input bit allow_rst,
                            input bit allow_to);
    bit         idle;
    bit         rst_now;
    bit         noise_ok;
    int         w;
    int         d;
    logic [3:0] exp_ready;
    idle     = (cyc >= free_at);
    rst_now  = allow_rst && (cyc >= last_grant + 2) && (cyc < wait_end) &&
               ($urandom_range(0, 31) == 0);
    noise_ok = (cyc == last_grant + 1) || (cyc > wait_end);
    rst       = rst_now;
    req_valid = all_valid ? 4'hF : 4'($urandom_range(0, 15));
    req_data  = $urandom;
    tx_done   = !rst_now && ((cyc == done_at) || (noise_ok && ($urandom_range(0, 3) == 0)));
    #1;
    w         = idle ? rr_winner(req_valid, m_ptr) : -1;
    exp_ready = (w >= 0) ? (4'd1 << w) : 4'd0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(!idle));
    check("tx_start", 32'(tx_start), 32'(cyc == last_grant + 1));
    check("tx_data", 32'(tx_data), 32'(exp_data));
    check("tx_chan", 32'(tx_chan), 32'(exp_chan));
    check("err_timeout", 32'(err_timeout), 32'(cyc == err_at));
    if (rst_now) begin
      reset_model(cyc + 1);
    end else if (w >= 0) begin
      last_grant = cyc;
      exp_data   = 8'(req_data >> (8 * w));
      exp_chan   = 3'(w);
      m_ptr      = (w + 1) % NREQ;
      order.push_back(w);
      if (allow_to && ($urandom_range(0, 7) == 0)) begin
        done_at  = -1;
        free_at  = cyc + 2 + TIMEOUT;
        wait_end = free_at - 1;
        err_at   = free_at;
      end else begin
        d        = (fixed_d > 0) ? fixed_d : $urandom_range(1, 6);
        done_at  = cyc + 1 + d;
        wait_end = done_at;
        free_at  = done_at + 1 + GAP;
      end
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
`ifdef UART_ARB_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    g0_valid  = '0;
    g0_data   = '0;
    g0_done   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    reset_model(cyc);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_chan", 32'(tx_chan), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_g0_busy", 32'(g0_busy), 32'd0);
    tick();

    // Zero-gap instance, requester 1 only: done in m, ready in m+1, start in m+2.
    g0_valid = 4'b0010;
    for (int f = 0; f < 3; f++) begin
      g0_data = $urandom;
      #1;
      check("g0_ready_idle", 32'(g0_ready), 32'h2);
      check("g0_start_low", 32'(g0_tx_start), 32'd0);
      tick();
      #1;
      check("g0_tx_start", 32'(g0_tx_start), 32'd1);
      check("g0_tx_data", 32'(g0_tx_data), 32'(g0_data[15:8]));
      check("g0_tx_chan", 32'(g0_tx_chan), 32'd1);
      check("g0_ready_issue", 32'(g0_ready), 32'd0);
      tick();
      #1;
      check("g0_start_drop", 32'(g0_tx_start), 32'd0);
      check("g0_busy_wait", 32'(g0_busy), 32'd1);
      tick();
      g0_done = 1'b1;
      #1;
      check("g0_ready_wait", 32'(g0_ready), 32'd0);
      check("g0_err", 32'(g0_err), 32'd0);
      tick();
      g0_done = 1'b0;
    end
    g0_valid = '0;

    // All requesters valid, done 5 cycles after each start: strict 0,1,2,3,0 rotation.
    order.delete();
    for (int i = 0; i < 41; i++) main_cycle(1'b1, 5, 1'b0, 1'b0);
    check("rr_count", 32'(order.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(i % NREQ));

    // Random traffic with noise done pulses, mid-frame resets and (if enabled) watchdog aborts.
    for (int i = 0; i < 1500; i++) main_cycle(1'b0, 0, 1'b1, to_en);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between NREQ byte requesters. Each requester offers a byte with a valid/ready handshake. A round-robin arbiter grants one requester, and the block issues a one-cycle start pulse with the byte to the transmitter. It then holds off further grants until the transmitter reports frame completion and an optional inter-frame gap has elapsed. It sits between the system-side byte producers and the UART transmitter/frame serializer.

## Interface
- NREQ, default 4: number of requesters; legal range 2..8.
- GAP, default 2: idle cycles inserted after each tx_done before the next grant; 0 allowed.
- TIMEOUT, default 2048: maximum WAIT cycles before abort (used only with UART_ARB_TIMEOUT_EN); must be ≥ 2.
- clk  in  1  clock; all logic runs on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte.
- req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i].
- req_ready  out  NREQ  combinational, one-hot grant; high only in IDLE.
- tx_start  out  1  registered one-cycle start pulse to the transmitter.
- tx_data  out  8  registered byte; stable from tx_start until the next grant.
- tx_chan  out  3  registered index of the granted requester.
- tx_done  in  1  transmitter frame-complete pulse.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on watchdog abort; constant 0 without the macro.

## Operation
- States:
  - IDLE: grant allowed.
  - ISSUE: tx_start high.
  - WAIT: awaiting tx_done.
  - GAP: counting the inter-frame gap.
- Round-robin pointer ptr (reset 0):
  - Winner = first i with req_valid[i], searching ptr, ptr+1, … with wrap mod NREQ.
  - req_ready[winner]=1 in IDLE only when some req_valid is high; all other bits 0.
- Transfer occurs at an edge where req_valid[i] & req_ready[i] (IDLE).
  - On that edge: tx_data<=byte, tx_chan<=i, tx_start<=1, ptr<=(i+1) mod NREQ, next state ISSUE.
- ISSUE → WAIT unconditionally; tx_start<=0 on that edge.
- WAIT → GAP on tx_done when GAP>0, else → IDLE. Gap counter loads GAP-1.
- GAP: counter decrements each cycle; → IDLE when the counter is 0.
- tx_done is ignored in IDLE, ISSUE and GAP; a tx_done in the same cycle as tx_start has no effect.
- A requester dropping req_valid before the transfer edge is not an error; re-arbitration happens every IDLE cycle.
- Reset values:
  - state IDLE, ptr 0.
  - tx_start 0, tx_data 8'h00, tx_chan 0.
  - err_timeout 0, gap and watchdog counters 0.
- Reset mid-frame: the block returns to IDLE immediately and the byte in flight is forgotten. The transmitter is reset by the same rst.

## Timing
- Grant latency: req_valid high in IDLE cycle n → transfer at the end of cycle n → tx_start high in cycle n+1 only.
- Minimum grant-to-grant spacing: tx_done seen in cycle m → next req_ready possible in cycle m+1+GAP.
- Throughput is one byte per transmitter frame plus GAP+2 cycles.
- Simultaneous requests from all NREQ requesters: each is served exactly once per NREQ grants, in ascending order from ptr.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without tx_done: err_timeout=1 for one cycle, → IDLE (no GAP).
  - ptr keeps its already-advanced value.
- UART_ARB_TIMEOUT_EN undefined: no watchdog logic, err_timeout tied 0, WAIT lasts until tx_done indefinitely.

## Structure
- Package uart_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, GAP) as 2-bit encoding;
  - the byte width constant 8 and the channel index width 3.
- Sub-module uart_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, index and any-valid flag.
  - It is instantiated once.

## Test plan
- Single request: req_valid=4'b0100, req_data byte2=8'hA5 → req_ready=4'b0100 in the same cycle; next cycle tx_start=1, tx_data=8'hA5, tx_chan=2; ptr becomes 3.
- All four valid continuously, tx_done returned 5 cycles after each tx_start, GAP=2 → grants in order 0,1,2,3,0; tx_done→next req_ready spacing exactly 3 cycles.
- tx_done pulsed during IDLE and GAP → no state change, no extra tx_start.
- Reset asserted in WAIT → next cycle busy=0, tx_start=0, tx_data=8'h00; a pending request is granted to requester 0 first.
- With UART_ARB_TIMEOUT_EN, TIMEOUT=16, tx_done never returned → err_timeout pulses once, 16 cycles after WAIT entry, then IDLE and the next requester is granted.
- GAP=0, back-to-back requests from requester 1 only → tx_done in cycle m, req_ready[1] in cycle m+1, tx_start in cycle m+2.
